// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
//   state_t    : controller states (IDLE, SHIFT, DONE)
//   WIDTH_MIN  : smallest supported operand length
//   WIDTH_MAX  : largest supported operand length
package serial_cmp_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_cmp_pkg

// File: rtl/serial_cmp_bit_cmp1.sv
// Single-bit combinational comparator cell.
//   a, b : operand bits
//   eq   : a == b
//   neq  : a != b
//   big  : a > b
//   sma  : a < b
module bit_cmp1 (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic neq,
  output logic big,
  output logic sma
);

  assign eq  = ~(a ^ b);
  assign neq = a ^ b;
  assign big = a & ~b;
  assign sma = ~a & b;

endmodule : bit_cmp1

// File: rtl/serial_cmp.sv
// Bit-serial magnitude comparator: operands arrive MSB first, one bit pair
// per valid cycle; the relation is resolved by the first differing bit pair.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a comparison (accepted in IDLE or DONE)
//   bit_valid  : a_bit/b_bit valid this cycle
//   a_bit      : operand A bit, MSB first
//   b_bit      : operand B bit, MSB first
//   busy       : comparison accepting bits
//   done       : one-cycle pulse when eq/neq/big/sma are updated
//   eq/neq/big/sma : registered relation of the last completed comparison
module serial_cmp
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic eq,
  output logic neq,
  output logic big,
  output logic sma
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             decided, decided_nxt;
  logic             rel_big, rel_big_nxt;
  logic             rel_sma, rel_sma_nxt;
  logic             busy_nxt, done_nxt;
  logic             eq_nxt, neq_nxt, big_nxt, sma_nxt;

  logic cell_eq, cell_neq, cell_big, cell_sma;

  // Per-bit decision for the current bit pair.
  bit_cmp1 u_bit_cmp1 (
    .a   (a_bit),
    .b   (b_bit),
    .eq  (cell_eq),
    .neq (cell_neq),
    .big (cell_big),
    .sma (cell_sma)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      decided <= 1'b0;
      rel_big <= 1'b0;
      rel_sma <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      eq      <= 1'b0;
      neq     <= 1'b0;
      big     <= 1'b0;
      sma     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      decided <= decided_nxt;
      rel_big <= rel_big_nxt;
      rel_sma <= rel_sma_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      eq      <= eq_nxt;
      neq     <= neq_nxt;
      big     <= big_nxt;
      sma     <= sma_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    decided_nxt = decided;
    rel_big_nxt = rel_big;
    rel_sma_nxt = rel_sma;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    eq_nxt      = eq;
    neq_nxt     = neq;
    big_nxt     = big;
    sma_nxt     = sma;

    unique case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          state_nxt   = SHIFT;
          cnt_nxt     = '0;
          decided_nxt = 1'b0;
          rel_big_nxt = 1'b0;
          rel_sma_nxt = 1'b0;
          busy_nxt    = 1'b1;
        end
      end

      SHIFT: begin
        busy_nxt = 1'b1;
        if (bit_valid) begin
          cnt_nxt = CNT_W'(cnt + 1'b1);
          // Only the first differing pair (MSB side) decides the relation.
          if (!decided && !cell_eq) begin
            decided_nxt = cell_neq;
            rel_big_nxt = cell_big;
            rel_sma_nxt = cell_sma;
          end
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            eq_nxt    = ~decided_nxt;
            neq_nxt   = decided_nxt;
            big_nxt   = rel_big_nxt;
            sma_nxt   = rel_sma_nxt;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule : serial_cmp
